// File: rtl/du_fw_loader_pkg.sv
// Shared debug-unit constants and loader state encodings.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package du_fw_loader_pkg;

    // Control bytes on the debug UART link; SOT/EOT are consumed by the
    // debug master, ACK/NAK are produced by the loader.
    localparam logic [7:0] DU_SOT = 8'h01;
    localparam logic [7:0] DU_EOT = 8'h04;
    localparam logic [7:0] DU_ACK = 8'h05;
    localparam logic [7:0] DU_NAK = 8'h15;

    // One-hot loader states.
    typedef enum logic [8:0] {
        ST_IDLE    = 9'b0_0000_0001,
        ST_LEN_LO  = 9'b0_0000_0010,
        ST_LEN_HI  = 9'b0_0000_0100,
        ST_CHK_LEN = 9'b0_0000_1000,
        ST_DATA    = 9'b0_0001_0000,
        ST_WRITE   = 9'b0_0010_0000,
        ST_CSUM    = 9'b0_0100_0000,
        ST_RESP    = 9'b0_1000_0000,
        ST_DONE    = 9'b1_0000_0000
    } ld_state_t;

endpackage

// File: rtl/du_fw_loader_byte_packer.sv
// Packs a byte stream into little-endian words (first byte -> bits [7:0]).
// Latency: word register complete the cycle after the 4th byte; word_vld flags that 4th byte combinationally.
// Backpressure: none; shifts only when en is high, holds word otherwise.
// Ports: clk/rst (sync, active high), clr (restart word), en + rx_byte (byte in), word/word_vld (out).
module du_fw_loader_byte_packer #(
    parameter int NB_WORD = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    input  logic [NB_BYTE-1:0] rx_byte,
    output logic [NB_WORD-1:0] word,
    output logic               word_vld
);

    logic [1:0] byte_cnt;

    // High while the byte being accepted is the last one of the word.
    assign word_vld = en && (byte_cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            byte_cnt <= 2'd0;
            word     <= '0;
        end else if (en) begin
            // Shift right so the earliest byte ends up in the LSBs.
            word     <= {rx_byte, word[NB_WORD-1:NB_BYTE]};
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/du_fw_loader.sv
// Debug-unit firmware loader: pops a length-prefixed, XOR-checksummed stream from the UART RX FIFO into IMEM from word 0, replies ACK/NAK.
// Latency: IMEM write one cycle after the 4th byte of a word is popped; ACK/NAK pushed once the checksum byte is popped and TX has room.
// Backpressure: stalls without side effects while RX is empty or TX is full; i_load_start low aborts to IDLE next cycle.
// Ports: clk/i_rst; i_load_start (enable), RX FIFO (i_rx_done, i_rx_data, o_rd), TX FIFO (i_tx_full, o_wr, o_tx_start, o_wdata),
//        IMEM (o_imem_we, o_imem_addr, o_imem_wdata), status (o_prog_len, o_done).
module du_fw_loader
    import du_fw_loader_pkg::*;
#(
    parameter int NB_INSTRUCTION = 32,
    parameter int NB_UART_DATA   = 8,
    parameter int NB_IMEM_ADDR   = 10
) (
    input  logic                      clk,
    input  logic                      i_rst,
    input  logic                      i_load_start,
    input  logic                      i_rx_done,
    input  logic [NB_UART_DATA-1:0]   i_rx_data,
    input  logic                      i_tx_full,
    output logic                      o_rd,
    output logic                      o_wr,
    output logic                      o_tx_start,
    output logic [NB_UART_DATA-1:0]   o_wdata,
    output logic                      o_imem_we,
    output logic [NB_IMEM_ADDR-1:0]   o_imem_addr,
    output logic [NB_INSTRUCTION-1:0] o_imem_wdata,
    output logic [15:0]               o_prog_len,
    output logic                      o_done
);

    // Capacity in words; 17 bits so a full 16-bit length compares without wrap.
    localparam logic [16:0] DEPTH = 17'(2 ** NB_IMEM_ADDR);

    ld_state_t                 state;
    logic [15:0]               len;
    logic [16:0]               word_cnt;
    logic [NB_UART_DATA-1:0]   csum;
    logic                      resp_ack;
    logic                      pop_state;
    logic                      pk_en;
    logic                      pk_clr;
    logic                      pk_last;
    logic [NB_INSTRUCTION-1:0] pk_word;

    // RX pops are combinational so a first-word-fall-through byte is
    // consumed in the same cycle the FSM uses it.
    assign pop_state  = (state == ST_LEN_LO) || (state == ST_LEN_HI) ||
                        (state == ST_DATA)   || (state == ST_CSUM);
    assign o_rd       = i_load_start && i_rx_done && pop_state;
    assign o_wr       = i_load_start && (state == ST_RESP) && !i_tx_full;
    assign o_tx_start = o_wr;
    assign o_imem_we  = i_load_start && (state == ST_WRITE);
    assign o_done     = (state == ST_DONE);

    // Address and data come straight from registers, so they stay stable
    // between writes.
    assign o_imem_addr  = word_cnt[NB_IMEM_ADDR-1:0];
    assign o_imem_wdata = pk_word;

    assign pk_en  = o_rd && (state == ST_DATA);
    assign pk_clr = (state == ST_IDLE) || (state == ST_LEN_LO);

    du_fw_loader_byte_packer #(
        .NB_WORD (NB_INSTRUCTION),
        .NB_BYTE (NB_UART_DATA)
    ) u_packer (
        .clk      (clk),
        .rst      (i_rst),
        .clr      (pk_clr),
        .en       (pk_en),
        .rx_byte  (i_rx_data),
        .word     (pk_word),
        .word_vld (pk_last)
    );

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            len        <= '0;
            word_cnt   <= '0;
            csum       <= '0;
            resp_ack   <= 1'b0;
            o_wdata    <= '0;
            o_prog_len <= '0;
        end else if (!i_load_start) begin
            // Abort or idle: counters are restarted on the next enable.
            state <= ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    word_cnt <= '0;
                    csum     <= '0;
                    state    <= ST_LEN_LO;
                end
                ST_LEN_LO: begin
                    if (i_rx_done) begin
                        len[7:0] <= i_rx_data;
                        state    <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (i_rx_done) begin
                        len[15:8] <= i_rx_data;
                        state     <= ST_CHK_LEN;
                    end
                end
                ST_CHK_LEN: begin
                    // Oversized images are refused before any data is popped.
                    if ({1'b0, len} > DEPTH) begin
                        o_wdata  <= NB_UART_DATA'(DU_NAK);
                        resp_ack <= 1'b0;
                        state    <= ST_RESP;
                    end else if (len == 16'd0) begin
                        state <= ST_CSUM;
                    end else begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (i_rx_done) begin
                        csum <= csum ^ i_rx_data;
                        if (pk_last) begin
                            state <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    word_cnt <= word_cnt + 17'd1;
                    state    <= (word_cnt + 17'd1 == {1'b0, len}) ? ST_CSUM : ST_DATA;
                end
                ST_CSUM: begin
                    if (i_rx_done) begin
                        if (i_rx_data == csum) begin
                            o_wdata    <= NB_UART_DATA'(DU_ACK);
                            resp_ack   <= 1'b1;
                            o_prog_len <= len;
                        end else begin
                            o_wdata  <= NB_UART_DATA'(DU_NAK);
                            resp_ack <= 1'b0;
                        end
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (!i_tx_full) begin
                        if (resp_ack) begin
                            state <= ST_DONE;
                        end else begin
                            // Host resends from the length field; IMEM is
                            // rewritten from word 0.
                            word_cnt <= '0;
                            csum     <= '0;
                            state    <= ST_LEN_LO;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_du_fw_loader.sv
// Self-checking bench for du_fw_loader: RX FIFO model, IMEM/TX scoreboards.
// Latency: n/a.
// Backpressure: drives random RX gaps and a held TX-full window.
module tb_du_fw_loader;

    localparam int DEPTH = 1024;
    localparam logic [7:0] ACK = 8'h05;
    localparam logic [7:0] NAK = 8'h15;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_load_start;
    logic        i_rx_done;
    logic [7:0]  i_rx_data;
    logic        i_tx_full;
    logic        o_rd;
    logic        o_wr;
    logic        o_tx_start;
    logic [7:0]  o_wdata;
    logic        o_imem_we;
    logic [9:0]  o_imem_addr;
    logic [31:0] o_imem_wdata;
    logic [15:0] o_prog_len;
    logic        o_done;

    always #5 clk = ~clk;

    du_fw_loader dut (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_load_start (i_load_start),
        .i_rx_done    (i_rx_done),
        .i_rx_data    (i_rx_data),
        .i_tx_full    (i_tx_full),
        .o_rd         (o_rd),
        .o_wr         (o_wr),
        .o_tx_start   (o_tx_start),
        .o_wdata      (o_wdata),
        .o_imem_we    (o_imem_we),
        .o_imem_addr  (o_imem_addr),
        .o_imem_wdata (o_imem_wdata),
        .o_prog_len   (o_prog_len),
        .o_done       (o_done)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_wr  = 0;
    int n_tx  = 0;
    int n_pop = 0;
    bit rx_gap = 1'b0;

    logic [7:0]  rx_q[$];
    logic [7:0]  tx_exp[$];
    logic [41:0] wr_exp[$];
    logic [31:0] words[$];
    logic [31:0] mem [DEPTH];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // RX FIFO model: a pop seen before an edge removes the head after it.
    always begin : rx_fifo
        bit popping;
        @(negedge clk);
        popping = o_rd;
        @(posedge clk);
        #1;
        if (popping && rx_q.size() != 0) void'(rx_q.pop_front());
        i_rx_done = (rx_q.size() != 0) && (!rx_gap || $urandom_range(0, 2) != 0);
        i_rx_data = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    end

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin : mon
        logic [41:0] e;
        if (o_rd) n_pop++;
        if (o_imem_we) begin
            n_wr++;
            mem[o_imem_addr] = o_imem_wdata;
            if (wr_exp.size() != 0) begin
                e = wr_exp.pop_front();
                check_eq("imem_addr", 32'(o_imem_addr), 32'(e[41:32]));
                check_eq("imem_wdata", o_imem_wdata, e[31:0]);
            end else begin
                check_eq("unexp_imem_we", 32'(o_imem_we), 32'd0);
            end
        end
        if (o_wr) begin
            n_tx++;
            check_eq("tx_start", 32'(o_tx_start), 32'd1);
            if (tx_exp.size() != 0) check_eq("tx_byte", 32'(o_wdata), 32'(tx_exp.pop_front()));
            else                    check_eq("unexp_tx", 32'(o_wr), 32'd0);
        end
    end

    // Queue a full frame; csum_err is XORed into the correct checksum.
    task automatic send_frame(input logic [31:0] w[$], input logic [7:0] csum_err);
        logic [7:0] cs;
        logic [7:0] by;
        int n;
        cs = 8'h00;
        n  = w.size();
        rx_q.push_back(8'(n));
        rx_q.push_back(8'(n >> 8));
        foreach (w[i]) begin
            for (int b = 0; b < 4; b++) begin
                by = w[i][8*b +: 8];
                rx_q.push_back(by);
                cs ^= by;
            end
            wr_exp.push_back({10'(i), w[i]});
        end
        rx_q.push_back(cs ^ csum_err);
        tx_exp.push_back((csum_err == 8'h00) ? ACK : NAK);
    endtask

    task automatic wait_tx(input int budget);
        for (int i = 0; i < budget && tx_exp.size() != 0; i++) @(posedge clk);
        tick(2);
        check_eq("tx_drained", 32'(tx_exp.size()), 32'd0);
        check_eq("wr_drained", 32'(wr_exp.size()), 32'd0);
    endtask

    task automatic wait_rx_empty(input int budget);
        for (int i = 0; i < budget && rx_q.size() != 0; i++) @(posedge clk);
        tick(1);
        check_eq("rx_drained", 32'(rx_q.size()), 32'd0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : stim
        int wr0, tx0, pop0;
        i_rst = 1'b1; i_load_start = 1'b0; i_tx_full = 1'b0;
        i_rx_done = 1'b0; i_rx_data = 8'h00;
        tick(3);
        check_eq("rst_ctl", 32'({o_rd, o_wr, o_tx_start, o_imem_we, o_done}), 32'd0);
        check_eq("rst_wdata", 32'(o_wdata), 32'd0);
        check_eq("rst_addr", 32'(o_imem_addr), 32'd0);
        check_eq("rst_imem_wdata", o_imem_wdata, 32'd0);
        check_eq("rst_prog_len", 32'(o_prog_len), 32'd0);
        i_rst = 1'b0;
        tick(2);

        // Basic two-word image.
        words = '{32'h0000_0013, 32'h0010_0093};
        i_load_start = 1'b1;
        send_frame(words, 8'h00);
        wait_tx(300);
        check_eq("t1_done", 32'(o_done), 32'd1);
        check_eq("t1_prog_len", 32'(o_prog_len), 32'd2);
        check_eq("t1_mem0", mem[0], 32'h0000_0013);
        check_eq("t1_mem1", mem[1], 32'h0010_0093);
        i_load_start = 1'b0;
        tick(2);
        check_eq("t1_done_drop", 32'(o_done), 32'd0);

        // Empty image.
        words.delete();
        wr0 = n_wr;
        i_load_start = 1'b1;
        send_frame(words, 8'h00);
        wait_tx(100);
        check_eq("n0_done", 32'(o_done), 32'd1);
        check_eq("n0_prog_len", 32'(o_prog_len), 32'd0);
        check_eq("n0_writes", 32'(n_wr - wr0), 32'd0);
        i_load_start = 1'b0;
        tick(2);

        // Bad checksum, then resend without leaving the enable.
        words = '{32'h0000_0013, 32'h0010_0093};
        i_load_start = 1'b1;
        send_frame(words, 8'h01);
        wait_tx(300);
        check_eq("nak_prog_len", 32'(o_prog_len), 32'd0);
        check_eq("nak_done", 32'(o_done), 32'd0);
        send_frame(words, 8'h00);
        wait_tx(300);
        check_eq("resend_done", 32'(o_done), 32'd1);
        check_eq("resend_prog_len", 32'(o_prog_len), 32'd2);
        check_eq("resend_mem1", mem[1], 32'h0010_0093);
        i_load_start = 1'b0;
        tick(2);

        // Oversized length refused after the length bytes only.
        pop0 = n_pop; wr0 = n_wr;
        i_load_start = 1'b1;
        rx_q.push_back(8'h01);
        rx_q.push_back(8'h04);
        tx_exp.push_back(NAK);
        wait_tx(100);
        check_eq("big_pops", 32'(n_pop - pop0), 32'd2);
        check_eq("big_writes", 32'(n_wr - wr0), 32'd0);
        check_eq("big_prog_len", 32'(o_prog_len), 32'd2);
        i_load_start = 1'b0;
        tick(2);

        // Full-capacity image.
        words.delete();
        for (int i = 0; i < DEPTH; i++) words.push_back($urandom);
        i_load_start = 1'b1;
        send_frame(words, 8'h00);
        wait_tx(8000);
        check_eq("full_prog_len", 32'(o_prog_len), 32'(DEPTH));
        check_eq("full_mem_last", mem[DEPTH-1], words[DEPTH-1]);
        i_load_start = 1'b0;
        tick(2);

        // Gapped RX and TX full held across the response.
        words = '{32'h1505_0401, $urandom, $urandom};
        rx_gap = 1'b1; i_tx_full = 1'b1;
        tx0 = n_tx;
        i_load_start = 1'b1;
        send_frame(words, 8'h00);
        wait_rx_empty(2000);
        tick(50);
        check_eq("full_hold_tx", 32'(n_tx - tx0), 32'd0);
        i_tx_full = 1'b0;
        wait_tx(100);
        check_eq("full_single_ack", 32'(n_tx - tx0), 32'd1);
        check_eq("gap_prog_len", 32'(o_prog_len), 32'd3);
        check_eq("gap_mem0", mem[0], 32'h1505_0401);
        rx_gap = 1'b0;
        i_load_start = 1'b0;
        tick(2);

        // Abort after six data bytes.
        wr0 = n_wr; tx0 = n_tx;
        i_load_start = 1'b1;
        rx_q.push_back(8'h04); rx_q.push_back(8'h00);
        rx_q.push_back(8'h11); rx_q.push_back(8'h22); rx_q.push_back(8'h33);
        rx_q.push_back(8'h44); rx_q.push_back(8'h55); rx_q.push_back(8'h66);
        wr_exp.push_back({10'd0, 32'h4433_2211});
        wait_rx_empty(200);
        tick(3);
        i_load_start = 1'b0;
        tick(1);
        rx_q.push_back(8'h77); rx_q.push_back(8'h88);
        tick(10);
        check_eq("abort_no_pop", 32'(rx_q.size()), 32'd2);
        check_eq("abort_writes", 32'(n_wr - wr0), 32'd1);
        check_eq("abort_tx", 32'(n_tx - tx0), 32'd0);
        check_eq("abort_prog_len", 32'(o_prog_len), 32'd3);
        check_eq("abort_done", 32'(o_done), 32'd0);
        rx_q.delete();
        tick(2);

        // Synchronous reset in the middle of a frame.
        i_load_start = 1'b1;
        rx_q.push_back(8'h02); rx_q.push_back(8'h00);
        rx_q.push_back(8'hAA); rx_q.push_back(8'hBB); rx_q.push_back(8'hCC);
        wait_rx_empty(200);
        tick(2);
        i_rst = 1'b1; i_load_start = 1'b0;
        tick(2);
        check_eq("mid_rst_ctl", 32'({o_rd, o_wr, o_tx_start, o_imem_we, o_done}), 32'd0);
        check_eq("mid_rst_wdata", 32'(o_wdata), 32'd0);
        check_eq("mid_rst_imem_wdata", o_imem_wdata, 32'd0);
        check_eq("mid_rst_addr", 32'(o_imem_addr), 32'd0);
        check_eq("mid_rst_prog_len", 32'(o_prog_len), 32'd0);
        i_rst = 1'b0;
        tick(3);
        check_eq("post_rst_prog_len", 32'(o_prog_len), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
